// File: rtl/pa_core_lsu.sv
// pa_core_lsu: single-port load/store unit between the core and the TCM.
// One request in flight at a time. The request is captured on acceptance,
// checked for alignment and range, and turned into a one-cycle TCM strobe.
// Loads return the lane-selected, extended read data one cycle after the
// TCM read data becomes valid.
module pa_core_lsu #(
    parameter logic [31:0] TCM_BASE = 32'h2000_0000,
    parameter int unsigned TCM_KB   = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    // core request
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [2:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    // core response
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    // TCM port 1
    output logic [31:0] tcm_addr_o,
    output logic        tcm_rd_o,
    output logic        tcm_we_o,
    output logic [2:0]  tcm_size_o,
    output logic [31:0] tcm_wdata_o,
    input  logic [31:0] tcm_rdata_i
);

    localparam logic [2:0]  SZ_B = 3'b001;
    localparam logic [2:0]  SZ_H = 3'b010;
    localparam logic [2:0]  SZ_W = 3'b100;
    // One past the last TCM byte; 33 bits so a TCM ending at 4 GiB still compares.
    localparam logic [32:0] TCM_END = {1'b0, TCM_BASE} + 33'(TCM_KB) * 33'd1024;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        we;
        logic        uns;
        logic [31:0] wdata;
    } lsu_req_t;

    state_t      state_q, state_d;
    lsu_req_t    req_q;
    logic        live_q;      // low during reset so ready stays low until the first edge
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        misalign;
    logic        out_of_range;
    logic        req_err;
    logic [31:0] rd_shift;
    logic [31:0] load_ext;

    assign req_ready_o = live_q && (state_q == S_IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    assign misalign     = ((req_size_i == SZ_H) && req_addr_i[0]) ||
                          ((req_size_i == SZ_W) && (req_addr_i[1:0] != 2'b00));
    assign out_of_range = ({1'b0, req_addr_i} < {1'b0, TCM_BASE}) ||
                          ({1'b0, req_addr_i} >= TCM_END);
    assign req_err      = misalign || out_of_range;

    // State register; async reset returns to IDLE and aborts any operation.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = req_err ? S_RESP : S_ACCESS;
            S_ACCESS: state_d = req_q.we ? S_RESP : S_WAIT;
            S_WAIT:   state_d = S_RESP;
            S_RESP:   if (rsp_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Request capture and response data; response regs clear once consumed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            live_q  <= 1'b0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                req_q.addr  <= req_addr_i;
                req_q.size  <= req_size_i;
                req_q.we    <= req_we_i;
                req_q.uns   <= req_unsigned_i;
                req_q.wdata <= req_wdata_i;
                rdata_q     <= '0;
                err_q       <= req_err;
            end else if (state_q == S_WAIT) begin
                rdata_q <= load_ext;
            end else if ((state_q == S_RESP) && rsp_ready_i) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    // Load lane select by address offset, then zero/sign extension.
    always_comb begin
        rd_shift = tcm_rdata_i >> {req_q.addr[1:0], 3'b000};
        load_ext = tcm_rdata_i;
        case (req_q.size)
            SZ_B: load_ext = req_q.uns ? {24'h0, rd_shift[7:0]}
                                       : {{24{rd_shift[7]}}, rd_shift[7:0]};
            SZ_H: load_ext = req_q.uns ? {16'h0, rd_shift[15:0]}
                                       : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_ext = tcm_rdata_i;
        endcase
    end

    // TCM port drive: live only in ACCESS, store data replicated across lanes.
    always_comb begin
        tcm_addr_o  = '0;
        tcm_size_o  = '0;
        tcm_rd_o    = 1'b0;
        tcm_we_o    = 1'b0;
        tcm_wdata_o = '0;
        if (state_q == S_ACCESS) begin
            tcm_addr_o = req_q.addr;
            tcm_size_o = req_q.size;
            tcm_rd_o   = !req_q.we;
            tcm_we_o   = req_q.we;
            if (req_q.we) begin
                case (req_q.size)
                    SZ_B:    tcm_wdata_o = {4{req_q.wdata[7:0]}};
                    SZ_H:    tcm_wdata_o = {2{req_q.wdata[15:0]}};
                    default: tcm_wdata_o = req_q.wdata;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pa_core_lsu.sv
// tb_pa_core_lsu: directed bench for pa_core_lsu with a small TCM model
// and a queue of expected responses.
module tb_pa_core_lsu;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [2:0]  SB = 3'b001, SH = 3'b010, SW = 3'b100;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [2:0]  req_size_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic [31:0] tcm_addr_o, tcm_wdata_o, tcm_rdata_i;
    logic        tcm_rd_o, tcm_we_o;
    logic [2:0]  tcm_size_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [64];

    pa_core_lsu dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .tcm_addr_o(tcm_addr_o), .tcm_rd_o(tcm_rd_o), .tcm_we_o(tcm_we_o),
        .tcm_size_o(tcm_size_o), .tcm_wdata_o(tcm_wdata_o), .tcm_rdata_i(tcm_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // TCM model: byte-lane writes, registered read data.
    always @(posedge clk_i) begin
        if (tcm_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if ((tcm_size_o == SW) ||
                    (tcm_size_o == SH && (b / 2) == int'(tcm_addr_o[1])) ||
                    (tcm_size_o == SB && b == int'(tcm_addr_o[1:0])))
                    mem[tcm_addr_o[7:2]][8*b +: 8] <= tcm_wdata_o[8*b +: 8];
            end
        end
        if (tcm_rd_o) tcm_rdata_i <= mem[tcm_addr_o[7:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request, track TCM strobes, compare the response, then
    // optionally hold rsp_ready_i low for 'hold' cycles before consuming it.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [2:0] size, input logic uns, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic [31:0] exp_wdata, input int hold);
        int k, nrd, nwe;
        logic [31:0] wd_seen, ad_seen, rd0;
        logic er0;
        exp_t e;
        k = 0;
        while (!req_ready_o && k < 20) begin tick(); k++; end
        check({tag, "/ready"}, 32'(req_ready_o), 32'd1);
        req_we_i = we; req_addr_i = addr; req_size_i = size;
        req_unsigned_i = uns; req_wdata_i = wdata; req_valid_i = 1'b1;
        e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_err ? 0 : (we ? 1 : 2);
        sb.push_back(e);
        rsp_ready_i = (hold == 0);
        tick();
        // garbage on the request bus after acceptance must not matter
        req_valid_i = 1'b0; req_addr_i = ~addr; req_wdata_i = ~wdata;
        req_size_i = 3'b111; req_we_i = ~we; req_unsigned_i = ~uns;
        k = 0; nrd = 0; nwe = 0; wd_seen = '0; ad_seen = '0;
        while (!rsp_valid_o && k < 10) begin
            if (tcm_rd_o) begin nrd++; ad_seen = tcm_addr_o; end
            if (tcm_we_o) begin nwe++; ad_seen = tcm_addr_o; wd_seen = tcm_wdata_o; end
            tick();
            k++;
        end
        e = sb.pop_front();
        check({tag, "/latency"}, 32'(k), 32'(e.lat));
        check({tag, "/rdata"}, rsp_rdata_o, e.rdata);
        check({tag, "/err"}, 32'(rsp_err_o), 32'(e.err));
        check({tag, "/ready_in_resp"}, 32'(req_ready_o), 32'd0);
        check({tag, "/rd_pulses"}, 32'(nrd), (!exp_err && !we) ? 32'd1 : 32'd0);
        check({tag, "/we_pulses"}, 32'(nwe), (!exp_err && we) ? 32'd1 : 32'd0);
        if (!exp_err) check({tag, "/tcm_addr"}, ad_seen, addr);
        if (!exp_err && we) check({tag, "/tcm_wdata"}, wd_seen, exp_wdata);
        rd0 = rsp_rdata_o; er0 = rsp_err_o;
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                // stray store during the hold must be ignored
                req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = BASE + 32'h10;
                req_size_i = SW; req_wdata_i = 32'h1111_1111;
            end else begin
                req_valid_i = 1'b0;
            end
            tick();
            check({tag, "/hold_valid"}, 32'(rsp_valid_o), 32'd1);
            check({tag, "/hold_rdata"}, rsp_rdata_o, rd0);
            check({tag, "/hold_err"}, 32'(rsp_err_o), 32'(er0));
            check({tag, "/hold_ready"}, 32'(req_ready_o), 32'd0);
            check({tag, "/hold_strobe"}, 32'({tcm_rd_o, tcm_we_o}), 32'd0);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        check({tag, "/done_valid"}, 32'(rsp_valid_o), 32'd0);
        check({tag, "/done_ready"}, 32'(req_ready_o), 32'd1);
    endtask

    function automatic logic [31:0] all_outs();
        return {req_ready_o, rsp_valid_o, rsp_err_o, tcm_rd_o, tcm_we_o, tcm_size_o} |
               rsp_rdata_o | tcm_addr_o | tcm_wdata_o;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        tcm_rdata_i = '0;
        rst_n_i = 1'b0; rsp_ready_i = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
        req_size_i = SW; req_unsigned_i = 1'b0; req_wdata_i = '0;

        // reset state
        tick(); tick();
        check("reset/outputs", all_outs(), 32'd0);
        rst_n_i = 1'b1;
        #1;
        check("reset/ready_before_edge", 32'(req_ready_o), 32'd0);
        tick();
        check("reset/ready_after_edge", 32'(req_ready_o), 32'd1);

        // word store then load
        do_req("st_w", 1'b1, BASE + 32'h10, SW, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'hDEAD_BEEF, 0);
        do_req("ld_w", 1'b0, BASE + 32'h10, SW, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, 0);

        // byte store replication, signed/unsigned byte loads
        do_req("st_b", 1'b1, BASE + 32'h13, SB, 1'b0, 32'hABCD_EF80, 32'h0, 1'b0, 32'h8080_8080, 0);
        do_req("ld_bs", 1'b0, BASE + 32'h13, SB, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 32'h0, 0);
        do_req("ld_bu", 1'b0, BASE + 32'h13, SB, 1'b1, 32'h0, 32'h0000_0080, 1'b0, 32'h0, 0);

        // half loads from word 0x8001_1234
        do_req("st_w2", 1'b1, BASE + 32'h10, SW, 1'b0, 32'h8001_1234, 32'h0, 1'b0, 32'h8001_1234, 0);
        do_req("ld_hs_hi", 1'b0, BASE + 32'h12, SH, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0, 32'h0, 0);
        do_req("ld_hs_lo", 1'b0, BASE + 32'h10, SH, 1'b0, 32'h0, 32'h0000_1234, 1'b0, 32'h0, 0);

        // half store replication and upper-half loads
        do_req("st_h", 1'b1, BASE + 32'h22, SH, 1'b0, 32'hA5A5_1234, 32'h0, 1'b0, 32'h1234_1234, 0);
        do_req("ld_hu", 1'b0, BASE + 32'h22, SH, 1'b1, 32'h0, 32'h0000_1234, 1'b0, 32'h0, 0);
        do_req("ld_b3", 1'b0, BASE + 32'h23, SB, 1'b0, 32'h0, 32'h0000_0012, 1'b0, 32'h0, 0);
        do_req("ld_b0", 1'b0, BASE + 32'h20, SB, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 32'h0, 0);

        // errors: misaligned and out of range, no strobes, latency N+1
        do_req("err_w_mis", 1'b0, BASE + 32'h2, SW, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 0);
        do_req("err_w_end", 1'b0, BASE + 32'h8000, SW, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 0);
        do_req("err_h_mis", 1'b0, BASE + 32'h11, SH, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 0);
        do_req("err_st_low", 1'b1, BASE - 32'h4, SW, 1'b0, 32'h5555_5555, 32'h0, 1'b1, 32'h0, 0);

        // last word of the TCM is valid
        do_req("st_last", 1'b1, BASE + 32'h7FFC, SW, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0, 32'hCAFE_F00D, 0);
        do_req("ld_last", 1'b0, BASE + 32'h7FFC, SW, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0, 0);

        // response back-pressure for 5 cycles with a stray request, then data unchanged
        do_req("ld_hold", 1'b0, BASE + 32'h10, SW, 1'b0, 32'h0, 32'h8001_1234, 1'b0, 32'h0, 5);
        do_req("ld_after", 1'b0, BASE + 32'h10, SW, 1'b0, 32'h0, 32'h8001_1234, 1'b0, 32'h0, 0);

        // reset asserted in WAIT aborts the load
        req_we_i = 1'b0; req_addr_i = BASE + 32'h10; req_size_i = SW;
        req_unsigned_i = 1'b0; req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        check("abort/access_rd", 32'(tcm_rd_o), 32'd1);
        tick();
        rst_n_i = 1'b0;
        #1;
        check("abort/outputs", all_outs(), 32'd0);
        tick();
        check("abort/outputs_held", all_outs(), 32'd0);
        rst_n_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort/no_rsp", 32'(rsp_valid_o), 32'd0);
        end
        check("abort/ready", 32'(req_ready_o), 32'd1);
        do_req("ld_post_rst", 1'b0, BASE + 32'h10, SW, 1'b0, 32'h0, 32'h8001_1234, 1'b0, 32'h0, 0);

        check("sb/empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
